// File: rtl/chop_demod_pkg.sv
// Shared definitions for chopper-channel blocks: sequencing states and
// saturation helpers that work on a wide signed intermediate.
package chop_demod_pkg;

  localparam int WIDE_WIDTH = 64;

  typedef logic signed [WIDE_WIDTH-1:0] wide_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Largest positive value of a w-bit two's complement number.
  function automatic wide_t full_scale(input int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  // Negation where the most negative code maps to positive full scale.
  function automatic wide_t sat_neg(input wide_t x, input int unsigned w);
    wide_t hi;
    hi = full_scale(w);
    if (x == -hi - wide_t'(1)) return hi;
    return -x;
  endfunction

  // Addition clamped to the w-bit signed range.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    wide_t hi;
    wide_t lo;
    wide_t s;
    hi = full_scale(w);
    lo = -hi - wide_t'(1);
    s  = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/chop_demod_period_acc.sv
// Saturating period accumulator and sample counter with clear/load/add
// controls; ovf is sticky until clear or reset.
module chop_period_acc
  import chop_demod_pkg::*;
#(
  parameter int ADC_WIDTH = 18,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        load,
  input  logic                        add,
  input  logic signed [ADC_WIDTH-1:0] sample,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic        [CNT_WIDTH-1:0] cnt,
  output logic                        ovf
);

  wide_t sample_ext;
  wide_t acc_ext;
  wide_t exact_sum;
  wide_t sat_sum;

  assign sample_ext = wide_t'(sample);
  assign acc_ext    = wide_t'(acc);
  assign exact_sum  = acc_ext + sample_ext;
  assign sat_sum    = sat_add(acc_ext, sample_ext, ACC_WIDTH);

  // load restarts the period from the current sample; add selects whether
  // that sample contributes.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= add ? ACC_WIDTH'(sample_ext) : '0;
      cnt <= add ? CNT_WIDTH'(1) : '0;
    end else if (add) begin
      acc <= ACC_WIDTH'(sat_sum);
      if (sat_sum != exact_sum) ovf <= 1'b1;
      if (&cnt) ovf <= 1'b1;
      else      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/chop_demod.sv
// Per-channel chopper demodulator: sign restoration, hold substitution and
// per-period integration aligned to the delayed chop phase.
module chop_demod
  import chop_demod_pkg::*;
#(
  parameter int ADC_WIDTH = 18,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        chop_en_i,
  input  logic                        chop_default_i,
  input  logic                        chop_i,
  input  logic                        hold_i,
  input  logic signed [ADC_WIDTH-1:0] adc_data_i,
  input  logic                        adc_valid_i,
  output logic signed [ADC_WIDTH-1:0] demod_data_o,
  output logic                        demod_valid_o,
  output logic                        demod_held_o,
  output logic signed [ACC_WIDTH-1:0] period_sum_o,
  output logic        [CNT_WIDTH-1:0] period_cnt_o,
  output logic                        period_valid_o,
  output logic                        ovf_o
);

  state_t                        state;
  logic                          prev_chop;
  logic signed [ADC_WIDTH-1:0]   last_good;
  logic signed [ADC_WIDTH-1:0]   d;
  logic                          chopped;
  logic                          boundary;
  logic                          acc_clear;
  logic                          acc_load;
  logic                          acc_add;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic        [CNT_WIDTH-1:0]   cnt;

  assign chopped  = chop_en_i && (chop_i != chop_default_i);
  assign boundary = adc_valid_i && (chop_i == chop_default_i) &&
                    (prev_chop != chop_default_i);

  always_comb begin
    // NOTE: d gets a default before the conditional so no latch is inferred.
    d = adc_data_i;
    if (chopped) d = ADC_WIDTH'(sat_neg(wide_t'(adc_data_i), ADC_WIDTH));
  end

  // A boundary in SYNC or RUN restarts the period from the boundary sample.
  assign acc_clear = (state == ST_IDLE);
  assign acc_load  = chop_en_i && boundary && (state != ST_IDLE);
  assign acc_add   = chop_en_i && adc_valid_i && !hold_i &&
                     ((state == ST_RUN) || acc_load);

  chop_period_acc #(
    .ADC_WIDTH(ADC_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_acc (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (acc_clear),
    .load   (acc_load),
    .add    (acc_add),
    .sample (d),
    .acc    (acc),
    .cnt    (cnt),
    .ovf    (ovf_o)
  );

  // NOTE: all state here is registered with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      prev_chop      <= 1'b0;
      last_good      <= '0;
      demod_data_o   <= '0;
      demod_valid_o  <= 1'b0;
      demod_held_o   <= 1'b0;
      period_sum_o   <= '0;
      period_cnt_o   <= '0;
      period_valid_o <= 1'b0;
    end else begin
      demod_valid_o  <= adc_valid_i;
      period_valid_o <= 1'b0;

      if (adc_valid_i) begin
        prev_chop <= chop_i;
        if (hold_i) begin
          demod_data_o <= last_good;
          demod_held_o <= 1'b1;
        end else begin
          demod_data_o <= d;
          demod_held_o <= 1'b0;
          last_good    <= d;
        end
      end

      case (state)
        ST_IDLE: if (chop_en_i) state <= ST_SYNC;
        ST_SYNC: begin
          if (!chop_en_i)    state <= ST_IDLE;
          else if (boundary) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!chop_en_i) begin
            state <= ST_IDLE;
          end else if (boundary) begin
            period_sum_o   <= acc;
            period_cnt_o   <= cnt;
            period_valid_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chop_demod.sv
// Directed bench for chop_demod: a default-width instance plus a narrow
// accumulator instance sharing the same stimulus for saturation cases.
module tb_chop_demod;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                chop_en;
  logic                chop_default;
  logic                chop;
  logic                hold;
  logic signed [17:0]  adc;
  logic                adc_valid;

  logic signed [17:0]  demod_data;
  logic                demod_valid;
  logic                demod_held;
  logic signed [31:0]  period_sum;
  logic        [15:0]  period_cnt;
  logic                period_valid;
  logic                ovf;

  logic signed [17:0]  s_demod_data;
  logic                s_demod_valid;
  logic                s_demod_held;
  logic signed [19:0]  s_period_sum;
  logic        [15:0]  s_period_cnt;
  logic                s_period_valid;
  logic                s_ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  chop_demod dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .chop_en_i     (chop_en),
    .chop_default_i(chop_default),
    .chop_i        (chop),
    .hold_i        (hold),
    .adc_data_i    (adc),
    .adc_valid_i   (adc_valid),
    .demod_data_o  (demod_data),
    .demod_valid_o (demod_valid),
    .demod_held_o  (demod_held),
    .period_sum_o  (period_sum),
    .period_cnt_o  (period_cnt),
    .period_valid_o(period_valid),
    .ovf_o         (ovf)
  );

  chop_demod #(.ACC_WIDTH(20)) dut_sat (
    .clk           (clk),
    .reset_n       (reset_n),
    .chop_en_i     (chop_en),
    .chop_default_i(chop_default),
    .chop_i        (chop),
    .hold_i        (hold),
    .adc_data_i    (adc),
    .adc_valid_i   (adc_valid),
    .demod_data_o  (s_demod_data),
    .demod_valid_o (s_demod_valid),
    .demod_held_o  (s_demod_held),
    .period_sum_o  (s_period_sum),
    .period_cnt_o  (s_period_cnt),
    .period_valid_o(s_period_valid),
    .ovf_o         (s_ovf)
  );

  task automatic check(input string tag, input longint got, input longint want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One valid sample; outputs for it are visible when this returns.
  task automatic send(input logic signed [17:0] a, input logic c, input logic h);
    adc       = a;
    chop      = c;
    hold      = h;
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_demod"},   demod_data,   0);
    check({tag, "_dvalid"},  demod_valid,  0);
    check({tag, "_held"},    demod_held,   0);
    check({tag, "_sum"},     period_sum,   0);
    check({tag, "_cnt"},     period_cnt,   0);
    check({tag, "_pvalid"},  period_valid, 0);
    check({tag, "_ovf"},     ovf,          0);
    check({tag, "_sat_sum"}, s_period_sum, 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    chop_en      = 1'b0;
    chop_default = 1'b0;
    chop         = 1'b0;
    hold         = 1'b0;
    adc          = '0;
    adc_valid    = 1'b0;

    repeat (3) step();
    check_reset_outputs("init_reset");
    reset_n = 1'b1;
    chop_en = 1'b1;
    step();

    // Demod sign and saturated negation while still synchronising.
    send(18'sd100, 1'b1, 1'b0);
    check("neg_100", demod_data, -100);
    check("neg_100_valid", demod_valid, 1);
    check("neg_100_held", demod_held, 0);
    send(-18'sd131072, 1'b1, 1'b0);
    check("neg_min", demod_data, 131071);
    send(18'sd50, 1'b0, 1'b0);
    check("sync_boundary_demod", demod_data, 50);
    check("sync_boundary_no_strobe", period_valid, 0);

    // Hold substitution inside a period.
    send(18'sd500, 1'b0, 1'b0);
    check("last_good_500", demod_data, 500);
    for (int i = 0; i < 3; i++) begin
      send(18'sd9999, 1'b0, 1'b1);
      check("hold_data", demod_data, 500);
      check("hold_flag", demod_held, 1);
      check("hold_no_strobe", period_valid, 0);
    end
    send(-18'sd20, 1'b1, 1'b0);
    check("neg_minus20", demod_data, 20);
    send(18'sd7, 1'b1, 1'b0);
    check("neg_7", demod_data, -7);
    send(18'sd3, 1'b0, 1'b0);
    check("p1_strobe", period_valid, 1);
    check("p1_sum", period_sum, 563);
    check("p1_cnt", period_cnt, 4);
    check("p1_demod", demod_data, 3);
    step();
    check("p1_strobe_1clk", period_valid, 0);
    check("idle_dvalid", demod_valid, 0);

    // Saturation: narrow accumulator clamps, wide one does not.
    chop_en = 1'b0;
    repeat (2) step();
    chop_en = 1'b1;
    step();
    send(18'sd131071, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send(18'sd131071, 1'b0, 1'b0);
    check("sat_ovf_set", s_ovf, 1);
    check("wide_ovf_clear", ovf, 0);
    send(18'sd0, 1'b1, 1'b1);
    send(18'sd0, 1'b0, 1'b1);
    check("sat_strobe", s_period_valid, 1);
    check("sat_sum", s_period_sum, 524287);
    check("sat_cnt", s_period_cnt, 16);
    check("sat_ovf_sticky", s_ovf, 1);
    check("wide_sum", period_sum, 2097136);
    check("wide_cnt", period_cnt, 16);
    chop_en = 1'b0;
    repeat (2) step();
    check("sat_ovf_cleared_idle", s_ovf, 0);

    // Generator pattern: change=4, max=8, hold=3, adc=10.
    chop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(18'sd10, 1'b1, (i < 3) ? 1'b1 : 1'b0);
      check("gen_prefix_no_strobe", period_valid, 0);
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        send(18'sd10, (i >= 4) ? 1'b1 : 1'b0, ((i % 4) < 3) ? 1'b1 : 1'b0);
        check("gen_strobe", period_valid, (p == 1 && i == 0) ? 1 : 0);
        if (p == 1 && i == 0) begin
          check("gen_sum", period_sum, 0);
          check("gen_cnt", period_cnt, 2);
        end
      end
    end
    send(18'sd10, 1'b0, 1'b0);
    check("gen_strobe2", period_valid, 1);
    check("gen_cnt2", period_cnt, 2);

    // Enable dropped mid-period, then resync.
    send(18'sd20, 1'b0, 1'b0);
    chop_en = 1'b0;
    send(18'sd30, 1'b1, 1'b0);
    check("dis_passthru", demod_data, 30);
    check("dis_no_strobe_a", period_valid, 0);
    send(18'sd40, 1'b0, 1'b0);
    check("dis_no_strobe_b", period_valid, 0);
    send(18'sd41, 1'b1, 1'b0);
    check("dis_passthru2", demod_data, 41);
    chop_en = 1'b1;
    send(18'sd7, 1'b1, 1'b0);
    check("reen_neg", demod_data, -7);
    send(18'sd7, 1'b1, 1'b0);
    send(18'sd1, 1'b0, 1'b0);
    check("reen_first_boundary", period_valid, 0);
    send(18'sd2, 1'b0, 1'b0);
    send(18'sd3, 1'b1, 1'b0);
    send(18'sd4, 1'b1, 1'b0);
    check("reen_no_strobe", period_valid, 0);
    send(18'sd5, 1'b0, 1'b0);
    check("reen_strobe", period_valid, 1);
    check("reen_sum", period_sum, -4);
    check("reen_cnt", period_cnt, 4);

    // Reset held for 3 clks while running, including a boundary sample.
    reset_n = 1'b0;
    send(18'sd100, 1'b1, 1'b0);
    check_reset_outputs("run_reset_a");
    send(18'sd100, 1'b0, 1'b0);
    check_reset_outputs("run_reset_b");
    send(18'sd100, 1'b1, 1'b0);
    check_reset_outputs("run_reset_c");
    reset_n = 1'b1;
    send(18'sd6, 1'b1, 1'b0);
    check("post_reset_demod", demod_data, -6);
    send(18'sd8, 1'b0, 1'b0);
    check("post_reset_no_strobe", period_valid, 0);
    check("post_reset_sum_zero", period_sum, 0);
    send(18'sd9, 1'b1, 1'b0);
    send(18'sd11, 1'b0, 1'b0);
    check("post_reset_strobe", period_valid, 1);
    check("post_reset_sum", period_sum, -1);
    check("post_reset_cnt", period_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
